// File: rtl/mux_scan_sequencer_if.sv
// Mux-side select/data pair plus the outgoing frame handshake of the scan sequencer.
// master = sequencer side, slave = mux model / frame consumer side.
interface mux_scan_sequencer_if #(
  parameter int DATA_W = 4
);
  logic [1:0]          sel_out;
  logic [DATA_W-1:0]   mux_data_in;
  logic [4*DATA_W-1:0] frame_out;
  logic                valid_out;
  logic                ready_in;

  modport master (
    output sel_out,
    input  mux_data_in,
    output frame_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  sel_out,
    output mux_data_in,
    input  frame_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the enabled mux channels (SETTLE cycles each), packs them into one frame; frame valid 1+N_en*SETTLE+1 edges after start.
// Backpressure: a finished scan stalls in DONE until the single output slot frees; frames are never dropped.
module mux_scan_sequencer #(
  parameter int DATA_W = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  cont_in,
  input  logic [3:0]            en_mask_in,
  output logic                  busy_out,
  mux_scan_sequencer_if.master  bus
);

  localparam int FRAME_W = 4 * DATA_W;
  localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   buf_q, buf_d;
  logic [3:0]           mask_q, mask_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 valid_q, valid_d;

  logic                 slot_free;
  logic                 load;
  logic                 nxt_vld;
  logic [1:0]           nxt_sel;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      buf_q   <= '0;
      mask_q  <= 4'd0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    mask_d    = mask_q;
    frame_d   = frame_q;
    load      = 1'b0;
    slot_free = !valid_q || bus.ready_in;

    // Next enabled channel above the current one; descending scan leaves the nearest.
    nxt_vld = 1'b0;
    nxt_sel = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        nxt_vld = 1'b1;
        nxt_sel = 2'(i);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_in && (en_mask_in != 4'd0)) begin
          mask_d  = en_mask_in;
          buf_d   = '0;
          sel_d   = lowest_ch(en_mask_in);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          buf_d[int'(sel_q)*DATA_W +: DATA_W] = bus.mux_data_in;
          cnt_d = '0;
          if (nxt_vld) begin
            sel_d = nxt_sel;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (slot_free) begin
          frame_d = buf_q;
          load    = 1'b1;
          if (cont_in) begin
            mask_d = en_mask_in;
            if (en_mask_in != 4'd0) begin
              buf_d   = '0;
              sel_d   = lowest_ch(en_mask_in);
              cnt_d   = '0;
              state_d = SCAN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load on the same edge as a consume keeps the slot occupied with the new frame.
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && bus.ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign bus.sel_out   = sel_q;
  assign bus.frame_out = frame_q;
  assign bus.valid_out = valid_q;
  assign busy_out      = (state_q == SCAN) || (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: mux model returns sel+1; frames checked through per-instance expectation queues.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start_in;
  logic       start3_in;
  logic       cont_in;
  logic [3:0] en_mask_in;
  logic       ready;
  logic       busy1;
  logic       busy3;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q3[$];

  mux_scan_sequencer_if #(.DATA_W(4)) m1 ();
  mux_scan_sequencer_if #(.DATA_W(4)) m3 ();

  assign m1.mux_data_in = {2'b00, m1.sel_out} + 4'd1;
  assign m3.mux_data_in = {2'b00, m3.sel_out} + 4'd1;
  assign m1.ready_in    = ready;
  assign m3.ready_in    = ready;

  mux_scan_sequencer #(.DATA_W(4), .SETTLE(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .cont_in    (cont_in),
    .en_mask_in (en_mask_in),
    .busy_out   (busy1),
    .bus        (m1)
  );

  mux_scan_sequencer #(.DATA_W(4), .SETTLE(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start3_in),
    .cont_in    (cont_in),
    .en_mask_in (en_mask_in),
    .busy_out   (busy3),
    .bus        (m3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst && m1.valid_out && m1.ready_in) begin
      exp = (q1.size() != 0) ? q1.pop_front() : 32'hDEAD_BEEF;
      chk("dut1_frame", {16'h0, m1.frame_out}, exp);
    end
    if (!rst && m3.valid_out && m3.ready_in) begin
      exp = (q3.size() != 0) ? q3.pop_front() : 32'hDEAD_BEEF;
      chk("dut3_frame", {16'h0, m3.frame_out}, exp);
    end
  end

  initial begin
    rst        = 1'b1;
    start_in   = 1'b0;
    start3_in  = 1'b0;
    cont_in    = 1'b0;
    en_mask_in = 4'h0;
    ready      = 1'b1;
    step();
    step();
    chk("rst_sel",   {30'h0, m1.sel_out}, 32'd0);
    chk("rst_frame", {16'h0, m1.frame_out}, 32'd0);
    chk("rst_valid", {31'h0, m1.valid_out}, 32'd0);
    chk("rst_busy",  {31'h0, busy1}, 32'd0);
    rst = 1'b0;
    step();

    // Single shot, all channels.
    en_mask_in = 4'hF;
    q1.push_back(32'h4321);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("t1_sel_e0",  {30'h0, m1.sel_out}, 32'd0);
    chk("t1_busy_e0", {31'h0, busy1}, 32'd1);
    step();
    chk("t1_sel_e1",  {30'h0, m1.sel_out}, 32'd1);
    step();
    chk("t1_sel_e2",  {30'h0, m1.sel_out}, 32'd2);
    step();
    chk("t1_sel_e3",  {30'h0, m1.sel_out}, 32'd3);
    step();
    chk("t1_valid_e4", {31'h0, m1.valid_out}, 32'd0);
    chk("t1_busy_e4",  {31'h0, busy1}, 32'd1);
    step();
    chk("t1_valid_e5", {31'h0, m1.valid_out}, 32'd1);
    chk("t1_frame_e5", {16'h0, m1.frame_out}, 32'h4321);
    chk("t1_busy_e5",  {31'h0, busy1}, 32'd0);
    step();
    chk("t1_valid_e6", {31'h0, m1.valid_out}, 32'd0);

    // Sparse mask 0101.
    en_mask_in = 4'b0101;
    q1.push_back(32'h0301);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("t2_sel_e0", {30'h0, m1.sel_out}, 32'd0);
    step();
    chk("t2_sel_e1", {30'h0, m1.sel_out}, 32'd2);
    step();
    chk("t2_valid_e2", {31'h0, m1.valid_out}, 32'd0);
    chk("t2_busy_e2",  {31'h0, busy1}, 32'd1);
    step();
    chk("t2_valid_e3", {31'h0, m1.valid_out}, 32'd1);
    chk("t2_frame_e3", {16'h0, m1.frame_out}, 32'h0301);
    step();

    // Continuous mode under backpressure.
    en_mask_in = 4'hF;
    cont_in    = 1'b1;
    ready      = 1'b0;
    q1.push_back(32'h4321);
    q1.push_back(32'h4321);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 5) begin
        chk("t3_valid_first", {31'h0, m1.valid_out}, 32'd1);
        chk("t3_frame_first", {16'h0, m1.frame_out}, 32'h4321);
      end
      if (k == 10) cont_in = 1'b0;
      if (k == 12 || k == 19) begin
        chk("t3_stall_sel",   {30'h0, m1.sel_out}, 32'd3);
        chk("t3_stall_busy",  {31'h0, busy1}, 32'd1);
        chk("t3_stall_valid", {31'h0, m1.valid_out}, 32'd1);
        chk("t3_stall_frame", {16'h0, m1.frame_out}, 32'h4321);
      end
    end
    ready = 1'b1;
    step();
    chk("t3_second_valid", {31'h0, m1.valid_out}, 32'd1);
    chk("t3_second_busy",  {31'h0, busy1}, 32'd0);
    step();
    chk("t3_drained_valid", {31'h0, m1.valid_out}, 32'd0);
    chk("t3_queue_empty",   q1.size(), 32'd0);

    // Start with empty mask is ignored.
    en_mask_in = 4'h0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("t4_zero_busy",  {31'h0, busy1}, 32'd0);
    chk("t4_zero_valid", {31'h0, m1.valid_out}, 32'd0);
    step();
    chk("t4_zero_busy2", {31'h0, busy1}, 32'd0);

    // Mid-scan start pulse and mask change have no effect.
    en_mask_in = 4'hF;
    q1.push_back(32'h4321);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("t4_sel_e0", {30'h0, m1.sel_out}, 32'd0);
    en_mask_in = 4'h0;
    step();
    chk("t4_sel_e1", {30'h0, m1.sel_out}, 32'd1);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("t4_sel_e2", {30'h0, m1.sel_out}, 32'd2);
    step();
    chk("t4_sel_e3", {30'h0, m1.sel_out}, 32'd3);
    step();
    step();
    chk("t4_valid_e5", {31'h0, m1.valid_out}, 32'd1);
    chk("t4_frame_e5", {16'h0, m1.frame_out}, 32'h4321);
    step();

    // Reset on the edge that would capture channel 2.
    en_mask_in = 4'hF;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    step();
    chk("t5_sel_e2", {30'h0, m1.sel_out}, 32'd2);
    rst = 1'b1;
    step();
    chk("t5_rst_sel",   {30'h0, m1.sel_out}, 32'd0);
    chk("t5_rst_valid", {31'h0, m1.valid_out}, 32'd0);
    chk("t5_rst_frame", {16'h0, m1.frame_out}, 32'd0);
    chk("t5_rst_busy",  {31'h0, busy1}, 32'd0);
    rst = 1'b0;
    step();
    q1.push_back(32'h4321);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk("t5_clean_valid", {31'h0, m1.valid_out}, 32'd1);
    chk("t5_clean_frame", {16'h0, m1.frame_out}, 32'h4321);
    step();

    // SETTLE = 3, only channel 3.
    en_mask_in = 4'b1000;
    q3.push_back(32'h4000);
    start3_in = 1'b1;
    step();
    start3_in = 1'b0;
    chk("t6_sel_e0",  {30'h0, m3.sel_out}, 32'd3);
    chk("t6_busy_e0", {31'h0, busy3}, 32'd1);
    step();
    chk("t6_sel_e1",   {30'h0, m3.sel_out}, 32'd3);
    chk("t6_valid_e1", {31'h0, m3.valid_out}, 32'd0);
    step();
    chk("t6_sel_e2",   {30'h0, m3.sel_out}, 32'd3);
    step();
    chk("t6_valid_e3", {31'h0, m3.valid_out}, 32'd0);
    chk("t6_busy_e3",  {31'h0, busy3}, 32'd1);
    step();
    chk("t6_valid_e4", {31'h0, m3.valid_out}, 32'd1);
    chk("t6_frame_e4", {16'h0, m3.frame_out}, 32'h4000);
    chk("t6_busy_e4",  {31'h0, busy3}, 32'd0);
    step();

    for (int i = 0; i < 50 && (q1.size() != 0 || q3.size() != 0); i++) step();
    chk("final_q1_empty", q1.size(), 32'd0);
    chk("final_q3_empty", q3.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
